dac_playback_ctrl: RTL and testbench
====================================

// Module: dac_playback_ctrl
// PURPOSE
//   Sequences read-out of the DAC waveform buffer in the dac_clk domain. Holds a
//   programmable window (start address, length), sample-rate divider and loop count.
//   Issues BRAM read strobes and addresses, and a sample_valid aligned to BRAM data.
//   Supports arm/trigger/stop control with a busy status and a done pulse.
// PARAMETERS
//   ADDR_W  16  buffer address width; addresses wrap modulo 2^ADDR_W
//   DIV_W   16  rate-divider width
//   LOOP_W   8  loop-count width; 0 = loop forever
//   RD_LAT   2  BRAM read latency (rd_ce -> dout valid), cycles
// PORTS
//   dac_clk         in   1       clock; all logic on posedge
//   resetn          in   1       synchronous, active-low reset
//   cfg_valid       in   1       config write strobe
//   cfg_ready       out  1       1 when state==IDLE; config accepted only when high
//   cfg_start       in   ADDR_W  window start address
//   cfg_length      in   ADDR_W  samples per pass, 1..2^ADDR_W-1
//   cfg_div         in   DIV_W   one read every cfg_div+1 cycles
//   cfg_loops       in   LOOP_W  passes to play; 0 = infinite
//   cfg_err         out  1       1-cycle pulse: cfg_valid with cfg_length==0 rejected
//   arm             in   1       IDLE -> ARMED
//   trigger         in   1       ARMED -> PLAY
//   stop            in   1       abort to IDLE from any state
//   rd_ce           out  1       BRAM read enable (ceb/oce)
//   rd_addr         out  ADDR_W  BRAM read address (adb)
//   sample_valid    out  1       rd_ce delayed by RD_LAT; marks valid dout
//   busy            out  1       1 in ARMED or PLAY
//   done            out  1       1-cycle pulse on normal completion of the last pass
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except cfg_ready=1; shadow config = start 0,
//     length 1, div 0, loops 1; sample_valid pipeline cleared.
//   All outputs are registered. An input sampled at edge N takes effect on outputs
//     at edge N+1.
//   FSM: IDLE, ARMED, PLAY, DONE.
//   IDLE
//     cfg_valid & cfg_length!=0 latches the shadow regs.
//     cfg_valid & cfg_length==0 pulses cfg_err; shadow regs unchanged.
//     arm -> ARMED. When arm and a valid cfg_valid arrive together, the new config
//       is latched and used.
//   ARMED: trigger -> PLAY; idx=0, div_cnt=0, loops_left=cfg_loops.
//   PLAY
//     div_cnt==0: rd_ce=1, rd_addr=start+idx (ADDR_W wrap), div_cnt<=div.
//     Otherwise: rd_ce=0, div_cnt decrements.
//     With div=0, rd_ce stays high every cycle. First strobe occurs the first
//       cycle in PLAY.
//     On a strobe with idx==length-1:
//       loops_left==1 -> DONE (idx frozen).
//       Otherwise idx=0, and loops_left decrements unless infinite (cfg_loops==0).
//     Other strobes: idx+1.
//   DONE: done=1 for one cycle, then IDLE.
//   stop: from ARMED/PLAY/DONE -> IDLE next edge. rd_ce=0 that edge, no done pulse.
//     stop has priority over trigger and over completion in the same cycle.
//     stop in IDLE is a no-op.
//   In-flight reads are not flushed: sample_valid drains RD_LAT cycles after the
//     last rd_ce, including after stop.
//   cfg_valid outside IDLE is ignored; cfg_ready=0. trigger outside ARMED and arm
//     outside IDLE are ignored.
//   resetn low mid-PLAY: IDLE next edge, rd_ce=0, sample_valid pipe cleared.
// TESTING
//   1. cfg start=0x0010 len=4 div=0 loops=1, arm, trigger
//      -> rd_addr 10,11,12,13 on consecutive cycles; done 1 cycle after the last
//         strobe; sample_valid lags rd_ce by 2.
//   2. start=0xFFFE len=4 div=2 loops=2
//      -> addrs FFFE,FFFF,0000,0001 twice, strobes every 3rd cycle; 8 strobes
//         total, then done.
//   3. loops=0 len=3, run 20 strobes then stop
//      -> addresses cycle start..start+2; rd_ce=0 the next cycle; busy=0;
//         no done pulse.
//   4. cfg_valid with len=0 -> cfg_err pulse, prior config retained; cfg_valid
//      during PLAY -> ignored, cfg_ready=0.
//   5. trigger+stop in the same ARMED cycle -> IDLE, no rd_ce. stop on the final
//      strobe cycle -> IDLE, no done.
//   6. resetn low mid-PLAY for 1 cycle -> all outputs at reset values; re-arm
//      plays from the shadow-reset defaults.

Source files
------------

// File: rtl/dac_playback_ctrl.sv
// DAC waveform playback sequencer: walks a programmable buffer window at a divided
// rate, issuing BRAM read strobes plus a read-latency-aligned sample_valid.
module dac_playback_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DIV_W  = 16,
  parameter int LOOP_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              dac_clk,
  input  logic              resetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_length,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [LOOP_W-1:0] cfg_loops,
  output logic              cfg_err,
  input  logic              arm,
  input  logic              trigger,
  input  logic              stop,
  output logic              rd_ce,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [DIV_W-1:0]  ONE_D = DIV_W'(1);
  localparam logic [LOOP_W-1:0] ONE_L = LOOP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] length_q, length_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [LOOP_W-1:0] loops_left_q, loops_left_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              rd_ce_q, rd_ce_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] sv_pipe_q, sv_pipe_d;

  logic strobe, pass_end, final_strobe, cfg_accept;

  // div_cnt/idx always describe the current PLAY cycle, so rd_ce_q mirrors strobe.
  assign strobe       = (state_q == S_PLAY) && (div_cnt_q == '0);
  assign pass_end     = strobe && (idx_q == length_q - ONE_A);
  assign final_strobe = pass_end && (loops_left_q == ONE_L);
  assign cfg_accept   = (state_q == S_IDLE) && cfg_valid && (cfg_length != '0);

  always_ff @(posedge dac_clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      start_q      <= '0;
      length_q     <= ONE_A;
      div_q        <= '0;
      loops_q      <= ONE_L;
      idx_q        <= '0;
      div_cnt_q    <= '0;
      loops_left_q <= '0;
      cfg_ready_q  <= 1'b1;
      cfg_err_q    <= 1'b0;
      rd_ce_q      <= 1'b0;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sv_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      length_q     <= length_d;
      div_q        <= div_d;
      loops_q      <= loops_d;
      idx_q        <= idx_d;
      div_cnt_q    <= div_cnt_d;
      loops_left_q <= loops_left_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      rd_ce_q      <= rd_ce_d;
      rd_addr_q    <= rd_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sv_pipe_q    <= sv_pipe_d;
    end
  end

  // stop wins over trigger and over completion of the final pass.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (stop)         state_d = S_IDLE;
        else if (trigger) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (stop)              state_d = S_IDLE;
        else if (final_strobe) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d      = start_q;
    length_d     = length_q;
    div_d        = div_q;
    loops_d      = loops_q;
    idx_d        = idx_q;
    div_cnt_d    = div_cnt_q;
    loops_left_d = loops_left_q;
    if (cfg_accept) begin
      start_d  = cfg_start;
      length_d = cfg_length;
      div_d    = cfg_div;
      loops_d  = cfg_loops;
    end
    if (state_q == S_ARMED && state_d == S_PLAY) begin
      idx_d        = '0;
      div_cnt_d    = '0;
      loops_left_d = loops_q;
    end else if (state_q == S_PLAY && state_d == S_PLAY) begin
      if (strobe) begin
        div_cnt_d = div_q;
        if (pass_end) begin
          idx_d = '0;
          // loops_left of zero means play forever
          if (loops_left_q != '0) loops_left_d = loops_left_q - ONE_L;
        end else begin
          idx_d = idx_q + ONE_A;
        end
      end else begin
        div_cnt_d = div_cnt_q - ONE_D;
      end
    end
  end

  always_comb begin
    cfg_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d == S_ARMED) || (state_d == S_PLAY);
    done_d       = (state_d == S_DONE);
    cfg_err_d    = (state_q == S_IDLE) && cfg_valid && (cfg_length == '0);
    rd_ce_d      = (state_d == S_PLAY) && (div_cnt_d == '0);
    rd_addr_d    = rd_ce_d ? (start_q + idx_d) : rd_addr_q;
    sv_pipe_d    = '0;
    sv_pipe_d[0] = rd_ce_q;
    for (int i = 1; i < RD_LAT; i++) sv_pipe_d[i] = sv_pipe_q[i-1];
  end

  assign cfg_ready    = cfg_ready_q;
  assign cfg_err      = cfg_err_q;
  assign rd_ce        = rd_ce_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_valid = sv_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Bench for dac_playback_ctrl: vector table, directed corner sequences and
// randomized playbacks checked against a cycle-schedule model.
`timescale 1ns/1ps
module tb_dac_playback_ctrl;
  localparam int ADDR_W = 16;
  localparam int DIV_W  = 16;
  localparam int LOOP_W = 8;
  localparam int RD_LAT = 2;

  logic              dac_clk = 1'b0;
  logic              resetn = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_start = '0;
  logic [ADDR_W-1:0] cfg_length = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [LOOP_W-1:0] cfg_loops = '0;
  logic              cfg_err;
  logic              arm = 1'b0;
  logic              trigger = 1'b0;
  logic              stop = 1'b0;
  logic              rd_ce;
  logic [ADDR_W-1:0] rd_addr;
  logic              sample_valid;
  logic              busy;
  logic              done;

  always #5 dac_clk = ~dac_clk;

  dac_playback_ctrl #(.ADDR_W(ADDR_W), .DIV_W(DIV_W), .LOOP_W(LOOP_W), .RD_LAT(RD_LAT)) dut (
    .dac_clk(dac_clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_start(cfg_start),
    .cfg_length(cfg_length), .cfg_div(cfg_div), .cfg_loops(cfg_loops), .cfg_err(cfg_err),
    .arm(arm), .trigger(trigger), .stop(stop),
    .rd_ce(rd_ce), .rd_addr(rd_addr), .sample_valid(sample_valid),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cv, st, ln, dv, lp, arm, trg, stp;
    int e_rdy, e_busy, e_err, e_ce, e_done, e_sv, e_addr;
  } vec_t;
  vec_t vec[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; arm = 0; trigger = 0; stop = 0;
  endtask

  // Reference: strobe number n lands on PLAY cycle n*(div+1); total strobes len*loops.
  function automatic bit m_ce(int k, int ln, int dv, int lp, int stop_at);
    if (k < 0) return 0;
    if (stop_at >= 0 && k > stop_at) return 0;
    if (k % (dv + 1) != 0) return 0;
    if (lp == 0) return 1;
    return (k / (dv + 1)) < ln * lp;
  endfunction

  task automatic run_play(input int st, input int ln, input int dv, input int lp,
                          input int stop_at, input bit combined);
    int p, l, last_k;
    bit stopped, e_busy, e_done, e_ce;
    p = dv + 1;
    l = (lp == 0) ? -1 : (ln * lp - 1) * p;
    if (stop_at >= 0 && (lp == 0 || stop_at <= l)) last_k = stop_at + RD_LAT + 2;
    else last_k = l + RD_LAT + 2;
    cfg_start = ADDR_W'(st); cfg_length = ADDR_W'(ln);
    cfg_div = DIV_W'(dv); cfg_loops = LOOP_W'(lp);
    cfg_valid = 1; arm = combined;
    tick();
    cfg_valid = 0;
    if (!combined) begin arm = 1; tick(); end
    arm = 0;
    chk("armed_busy", busy, 1);
    chk("armed_ready", cfg_ready, 0);
    trigger = 1;
    tick();
    trigger = 0;
    for (int k = 0; k <= last_k; k++) begin
      stopped = (stop_at >= 0) && (k > stop_at);
      e_ce    = m_ce(k, ln, dv, lp, stop_at);
      e_busy  = !stopped && (lp == 0 || k <= l);
      e_done  = !stopped && (lp != 0) && (k == l + 1);
      chk($sformatf("ce@%0d", k), rd_ce, e_ce);
      chk($sformatf("sv@%0d", k), sample_valid, m_ce(k - RD_LAT, ln, dv, lp, stop_at));
      chk($sformatf("busy@%0d", k), busy, e_busy);
      chk($sformatf("done@%0d", k), done, e_done);
      chk($sformatf("ready@%0d", k), cfg_ready, !e_busy && !e_done);
      if (e_ce) chk($sformatf("addr@%0d", k), rd_addr, (st + (k / p) % ln) & 'hFFFF);
      stop = (k == stop_at);
      tick();
      stop = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cv st ln dv lp arm trg stp | rdy busy err ce done sv addr
    vec[0]  = '{1,'h10,4,0,1, 0,0,0, 1,0,0,0,0,0,0};
    vec[1]  = '{0,0,0,0,0,    1,0,0, 0,1,0,0,0,0,0};
    vec[2]  = '{0,0,0,0,0,    0,1,0, 0,1,0,1,0,0,'h10};
    vec[3]  = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,0,'h11};
    vec[4]  = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,1,'h12};
    vec[5]  = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,1,'h13};
    vec[6]  = '{0,0,0,0,0,    0,0,0, 0,0,0,0,1,1,0};
    vec[7]  = '{0,0,0,0,0,    0,0,0, 1,0,0,0,0,1,0};
    vec[8]  = '{1,'h500,0,5,3,0,0,0, 1,0,1,0,0,0,0};
    vec[9]  = '{0,0,0,0,0,    0,1,0, 1,0,0,0,0,0,0};
    vec[10] = '{0,0,0,0,0,    1,0,0, 0,1,0,0,0,0,0};
    vec[11] = '{0,0,0,0,0,    0,1,0, 0,1,0,1,0,0,'h10};
    vec[12] = '{1,0,0,0,0,    0,0,0, 0,1,0,1,0,0,'h11};
    vec[13] = '{1,'h99,5,3,7, 0,0,0, 0,1,0,1,0,1,'h12};
    vec[14] = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,1,'h13};
    vec[15] = '{0,0,0,0,0,    0,0,0, 0,0,0,0,1,1,0};
    vec[16] = '{0,0,0,0,0,    0,0,0, 1,0,0,0,0,1,0};
    vec[17] = '{0,0,0,0,0,    0,0,0, 1,0,0,0,0,0,0};
    vec[18] = '{0,0,0,0,0,    1,0,0, 0,1,0,0,0,0,0};
    vec[19] = '{0,0,0,0,0,    0,1,0, 0,1,0,1,0,0,'h10};
    vec[20] = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,0,'h11};
    vec[21] = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,1,'h12};
    vec[22] = '{0,0,0,0,0,    0,0,0, 0,1,0,1,0,1,'h13};
    vec[23] = '{0,0,0,0,0,    0,0,0, 0,0,0,0,1,1,0};

    resetn = 0;
    tick(); tick();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ce", rd_ce, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    resetn = 1;

    foreach (vec[i]) begin
      cfg_valid  = vec[i].cv[0];
      cfg_start  = ADDR_W'(vec[i].st);
      cfg_length = ADDR_W'(vec[i].ln);
      cfg_div    = DIV_W'(vec[i].dv);
      cfg_loops  = LOOP_W'(vec[i].lp);
      arm = vec[i].arm[0]; trigger = vec[i].trg[0]; stop = vec[i].stp[0];
      tick();
      chk($sformatf("v%0d_ready", i), cfg_ready, vec[i].e_rdy);
      chk($sformatf("v%0d_busy", i), busy, vec[i].e_busy);
      chk($sformatf("v%0d_err", i), cfg_err, vec[i].e_err);
      chk($sformatf("v%0d_ce", i), rd_ce, vec[i].e_ce);
      chk($sformatf("v%0d_done", i), done, vec[i].e_done);
      chk($sformatf("v%0d_sv", i), sample_valid, vec[i].e_sv);
      if (vec[i].e_ce != 0) chk($sformatf("v%0d_addr", i), rd_addr, vec[i].e_addr);
    end
    idle_inputs();
    tick();

    run_play('hFFFE, 4, 2, 2, -1, 0);
    run_play('h0100, 3, 0, 0, 19, 0);
    run_play('h0200, 3, 1, 1, 4, 0);

    // trigger and stop together while armed
    cfg_start = 'h0300; cfg_length = 2; cfg_div = 0; cfg_loops = 1; cfg_valid = 1;
    tick();
    cfg_valid = 0; arm = 1;
    tick();
    arm = 0; trigger = 1; stop = 1;
    tick();
    idle_inputs();
    chk("trgstop_ready", cfg_ready, 1);
    chk("trgstop_busy", busy, 0);
    chk("trgstop_ce", rd_ce, 0);
    tick();
    chk("trgstop_ce2", rd_ce, 0);
    chk("trgstop_done", done, 0);
    tick(); tick();
    chk("trgstop_sv", sample_valid, 0);

    // reset pulse mid-PLAY, then replay from reset-default config
    cfg_start = 'h0040; cfg_length = 3; cfg_div = 1; cfg_loops = 0; cfg_valid = 1;
    tick();
    cfg_valid = 0; arm = 1;
    tick();
    arm = 0; trigger = 1;
    tick();
    trigger = 0;
    tick(); tick();
    chk("midplay_ce", rd_ce, 1);
    resetn = 0;
    tick();
    resetn = 1;
    chk("mrst_ready", cfg_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_ce", rd_ce, 0);
    chk("mrst_addr", rd_addr, 0);
    chk("mrst_sv", sample_valid, 0);
    chk("mrst_done", done, 0);
    tick();
    chk("mrst_sv2", sample_valid, 0);
    arm = 1;
    tick();
    arm = 0; trigger = 1;
    tick();
    trigger = 0;
    chk("dflt_ce", rd_ce, 1);
    chk("dflt_addr", rd_addr, 0);
    tick();
    chk("dflt_ce_end", rd_ce, 0);
    chk("dflt_done", done, 1);
    tick();
    chk("dflt_ready", cfg_ready, 1);
    chk("dflt_sv", sample_valid, 1);
    chk("dflt_done_end", done, 0);
    tick();

    for (int r = 0; r < 30; r++) begin
      int st, ln, dv, lp, l, sa;
      st = ($urandom_range(0, 1) == 1) ? ('hFFF0 + $urandom_range(0, 15)) : $urandom_range(0, 'hFFFF);
      ln = $urandom_range(1, 6);
      dv = $urandom_range(0, 3);
      lp = $urandom_range(0, 3);
      l  = (ln * lp - 1) * (dv + 1);
      if (lp == 0) sa = $urandom_range(0, 40);
      else if ($urandom_range(0, 3) == 0) sa = $urandom_range(0, l + 3);
      else sa = -1;
      run_play(st, ln, dv, lp, sa, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
